// File: rtl/mul_pkg.sv
// -----------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the iterative radix-4 Booth multiply unit.
//   XLEN    : operand width (only 64 is supported)
//   NWIN64  : number of Booth windows for a 64-bit multiply
//   NWIN32  : number of Booth windows for a 32-bit word multiply (mulw)
//   state_e : sequencer state encoding
//   SS/SU/UU: mul_signed encodings
// -----------------------------------------------------------------------------
package mul_pkg;

    localparam int XLEN   = 64;
    localparam int NWIN64 = 33;
    localparam int NWIN32 = 17;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] SS = 2'b11;
    localparam logic [1:0] SU = 2'b10;
    localparam logic [1:0] UU = 2'b00;

    // Sign-extend the low 32 bits of a product to a 64-bit word result.
    function automatic logic [63:0] sext_word(input logic [31:0] w);
        return {{32{w[31]}}, w};
    endfunction

endpackage

// File: rtl/booth_win_shift.sv
// -----------------------------------------------------------------------------
// booth_win_shift
// Operand extension and Booth window shifter for booth_iter_acc.
// On i_load the multiplicand is extended to 65 bits and the multiplier is
// extended to 66 bits with a 0 appended below bit 0, forming the 67-bit
// window register ys. While i_shift is high ys moves right by two bits per
// cycle with sign fill, presenting the next 3-bit radix-4 Booth window.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   i_load       in   capture and extend operands
//   i_shift      in   advance ys by one radix-4 window
//   i_mulw       in   32-bit word multiply (use operand bits [31:0])
//   i_mul_signed in   2-bit signedness encoding (SS/SU/UU)
//   i_x          in   multiplicand
//   i_y          in   multiplier
//   o_x65        out  extended multiplicand
//   o_src        out  current Booth window ys[2:0]
//   o_zero       out  every remaining window (current included) is 000 or 111
// -----------------------------------------------------------------------------
module booth_win_shift
    import mul_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_load,
    input  logic                   i_shift,
    input  logic                   i_mulw,
    input  logic [1:0]             i_mul_signed,
    input  logic [XLEN-1:0]        i_x,
    input  logic [XLEN-1:0]        i_y,
    output logic [XLEN:0]          o_x65,
    output logic [2:0]             o_src,
    output logic                   o_zero
);

    logic                    w_sx;
    logic                    w_sy;
    logic [XLEN:0]           w_x65;
    logic [XLEN+1:0]         w_y66;

    logic [XLEN:0]           r_x65;
    logic signed [XLEN+2:0]  r_ys;

    // x is signed whenever the top signedness bit is set; y only for SS.
    // For mulw both follow SS, which only affects bits above 31 and so
    // never changes the sign-extended word result.
    always_comb begin
        w_sx = i_mul_signed[1];
        w_sy = (i_mul_signed == SS);
        if (i_mulw) begin
            w_x65 = {{33{i_x[31] & w_sy}}, i_x[31:0]};
            w_y66 = {{34{i_y[31] & w_sy}}, i_y[31:0]};
        end else begin
            w_x65 = {i_x[XLEN-1] & w_sx, i_x};
            w_y66 = {{2{i_y[XLEN-1] & w_sy}}, i_y};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x65 <= '0;
            r_ys  <= '0;
        end else if (i_load) begin
            r_x65 <= w_x65;
            r_ys  <= {w_y66, 1'b0};
        end else if (i_shift) begin
            r_ys  <= r_ys >>> 2;
        end
    end

    assign o_x65  = r_x65;
    assign o_src  = r_ys[2:0];
    // Sign fill keeps the upper bits equal to the top bit, so once every bit
    // matches, all later windows are 000 or 111 and contribute nothing.
    assign o_zero = (r_ys == '0) || (&r_ys);

endmodule

// File: rtl/booth_iter_acc.sv
// -----------------------------------------------------------------------------
// booth_iter_acc
// Iterative radix-4 Booth multiply sequencer and accumulator. Accepts a
// request in IDLE, feeds one Booth window per cycle to the external
// partial-product generator, accumulates the returned partial product shifted
// by 2*i, and strobes out_valid for one cycle with the 128-bit product (or a
// sign-extended 32-bit word result for mulw).
//
// Optional build macro MUL_EARLY_EXIT_EN: when defined, the sequencer leaves
// BUSY as soon as every remaining Booth window is zero, giving data-dependent
// latency. Results are identical with or without the macro.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   mul_valid    in   request valid
//   mul_ready    out  unit can accept (IDLE only)
//   flush        in   abort current operation
//   mulw         in   32-bit word multiply
//   mul_signed   in   11 SS, 10 SU, 0x UU
//   multiplicand in   operand x
//   multiplier   in   operand y
//   pg_x         out  extended multiplicand to generator (0 outside BUSY)
//   pg_src       out  Booth window to generator (000 outside BUSY)
//   pg_part      in   partial product from generator
//   out_valid    out  one-cycle result strobe
//   result_hi    out  product[127:64] (0 for mulw)
//   result_lo    out  product[63:0] (sign-extended word for mulw)
// -----------------------------------------------------------------------------
module booth_iter_acc #(
    parameter int XLEN = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mul_valid,
    output logic                  mul_ready,
    input  logic                  flush,
    input  logic                  mulw,
    input  logic [1:0]            mul_signed,
    input  logic [XLEN-1:0]       multiplicand,
    input  logic [XLEN-1:0]       multiplier,
    output logic [XLEN:0]         pg_x,
    output logic [2:0]            pg_src,
    input  logic [2*XLEN-1:0]     pg_part,
    output logic                  out_valid,
    output logic [XLEN-1:0]       result_hi,
    output logic [XLEN-1:0]       result_lo
);
    import mul_pkg::*;

`ifdef MUL_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    state_e              r_state;
    logic [5:0]          r_cnt;
    logic [2*XLEN-1:0]   r_acc;
    logic                r_mulw;
    logic                r_out_valid;
    logic [XLEN-1:0]     r_res_hi;
    logic [XLEN-1:0]     r_res_lo;

    logic                w_accept;
    logic                w_busy;
    logic                w_last_win;
    logic                w_win_zero;
    logic                w_finish;
    logic [XLEN:0]       w_x65;
    logic [2:0]          w_src;
    logic [2*XLEN-1:0]   w_part_sh;
    logic [2*XLEN-1:0]   w_acc_next;

    assign w_accept   = mul_valid && (r_state == IDLE) && !flush;
    assign w_busy     = (r_state == BUSY);
    assign w_last_win = (r_cnt == (r_mulw ? 6'(NWIN32 - 1) : 6'(NWIN64 - 1)));
    assign w_finish   = w_last_win || (EARLY_EXIT && w_win_zero);

    booth_win_shift u_win (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_accept),
        .i_shift      (w_busy),
        .i_mulw       (mulw),
        .i_mul_signed (mul_signed),
        .i_x          (multiplicand),
        .i_y          (multiplier),
        .o_x65        (w_x65),
        .o_src        (w_src),
        .o_zero       (w_win_zero)
    );

    // Window i carries weight 4^i; the 128-bit wrap gives the product mod 2^128.
    assign w_part_sh  = pg_part << {r_cnt, 1'b0};
    assign w_acc_next = r_acc + w_part_sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_mulw      <= 1'b0;
            r_out_valid <= 1'b0;
            r_res_hi    <= '0;
            r_res_lo    <= '0;
        end else begin
            r_out_valid <= 1'b0;
            if (flush) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_acc   <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (mul_valid) begin
                            r_state <= BUSY;
                            r_cnt   <= '0;
                            r_acc   <= '0;
                            r_mulw  <= mulw;
                        end
                    end
                    BUSY: begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + 6'd1;
                        if (w_finish) begin
                            // Results are taken from the sum that includes
                            // this cycle's partial, so they are valid in DONE.
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                            if (r_mulw) begin
                                r_res_hi <= '0;
                                r_res_lo <= sext_word(w_acc_next[31:0]);
                            end else begin
                                r_res_hi <= w_acc_next[2*XLEN-1:XLEN];
                                r_res_lo <= w_acc_next[XLEN-1:0];
                            end
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign mul_ready = (r_state == IDLE);
    assign pg_x      = w_busy ? w_x65 : '0;
    assign pg_src    = w_busy ? w_src : 3'b000;
    assign out_valid = r_out_valid;
    assign result_hi = r_res_hi;
    assign result_lo = r_res_lo;

endmodule

// File: tb/tb_booth_iter_acc.sv
module tb_booth_iter_acc;
    import mul_pkg::*;

`ifdef MUL_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          mul_valid;
    logic          mul_ready;
    logic          flush;
    logic          mulw;
    logic [1:0]    mul_signed;
    logic [63:0]   multiplicand;
    logic [63:0]   multiplier;
    logic [64:0]   pg_x;
    logic [2:0]    pg_src;
    logic [127:0]  pg_part;
    logic          out_valid;
    logic [63:0]   result_hi;
    logic [63:0]   result_lo;

    always #5 clk = ~clk;

    booth_iter_acc #(.XLEN(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .mul_valid    (mul_valid),
        .mul_ready    (mul_ready),
        .flush        (flush),
        .mulw         (mulw),
        .mul_signed   (mul_signed),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .pg_x         (pg_x),
        .pg_src       (pg_src),
        .pg_part      (pg_part),
        .out_valid    (out_valid),
        .result_hi    (result_hi),
        .result_lo    (result_lo)
    );

    // Partial-product generator: radix-4 Booth digit times signed x65.
    function automatic logic [127:0] gen(input logic [64:0] x, input logic [2:0] s);
        logic signed [127:0] xs;
        xs = {{63{x[64]}}, x};
        case (s)
            3'b001, 3'b010: return xs;
            3'b011:         return xs <<< 1;
            3'b100:         return -(xs <<< 1);
            3'b101, 3'b110: return -xs;
            default:        return '0;
        endcase
    endfunction

    always_comb pg_part = gen(pg_x, pg_src);

    // Reference product straight from the operand signedness rules.
    function automatic logic [127:0] prod(input logic [1:0] ms, input logic w,
                                          input logic [63:0] x, input logic [63:0] y);
        logic signed [127:0] a, b;
        logic [127:0] p;
        if (w) begin
            a = (ms == 2'b11) ? {{96{x[31]}}, x[31:0]} : {96'b0, x[31:0]};
            b = (ms == 2'b11) ? {{96{y[31]}}, y[31:0]} : {96'b0, y[31:0]};
            p = a * b;
            return {64'b0, {32{p[31]}}, p[31:0]};
        end
        a = ms[1]          ? {{64{x[63]}}, x} : {64'b0, x};
        b = (ms == 2'b11)  ? {{64{y[63]}}, y} : {64'b0, y};
        p = a * b;
        return p;
    endfunction

    // Cycles from accept cycle to out_valid cycle.
    function automatic int lat_of(input logic [1:0] ms, input logic w, input logic [63:0] y);
        logic signed [66:0] yv, r;
        logic sy;
        int n;
        sy = (ms == 2'b11);
        n  = w ? NWIN32 : NWIN64;
        yv = w ? {{34{y[31] & sy}}, y[31:0], 1'b0} : {{2{y[63] & sy}}, y, 1'b0};
        for (int j = 0; j < n; j++) begin
            r = yv >>> (2 * j);
            if (EARLY && (r == 0 || r == -1)) return j + 2;
        end
        return n + 1;
    endfunction

    typedef struct {
        int          due;
        logic [63:0] hi;
        logic [63:0] lo;
    } exp_t;

    exp_t        q[$];
    int          acc_log[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          chk_en = 1'b0;
    int          busy_lo = 0;
    int          busy_hi = -1;
    int          last_acc_c = 0;
    int          last_due = 0;
    logic [63:0] last_hi = '0;
    logic [63:0] last_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the model's view of the unit.
    always @(negedge clk) begin
        bit due_now;
        bit busy;
        if (chk_en) begin
            due_now = (q.size() > 0) && (q[0].due == cyc);
            busy    = (cyc >= busy_lo) && (cyc <= busy_hi);
            chk("out_valid", 128'(out_valid), 128'(due_now));
            chk("mul_ready", 128'(mul_ready), 128'(!busy));
            if (!busy) chk("pg_idle", 128'({pg_x, pg_src}), 128'(0));
            if (due_now) begin
                chk("result_hi", 128'(result_hi), 128'(q[0].hi));
                chk("result_lo", 128'(result_lo), 128'(q[0].lo));
                last_hi  = result_hi;
                last_lo  = result_lo;
                last_due = cyc;
                void'(q.pop_front());
            end
        end
    end

    // Apply the rules to the inputs about to be sampled at the next edge.
    task automatic step();
        int c;
        int lat;
        logic [127:0] p;
        c = cyc;
        if (rst || flush) begin
            while (q.size() > 0 && q[q.size()-1].due > c) void'(q.pop_back());
            if (c <= busy_hi) busy_hi = c;
        end else if (mul_valid && c > busy_hi) begin
            lat = lat_of(mul_signed, mulw, multiplier);
            p   = prod(mul_signed, mulw, multiplicand, multiplier);
            q.push_back('{c + lat, p[127:64], p[63:0]});
            busy_lo    = c + 1;
            busy_hi    = c + lat;
            last_acc_c = c;
            acc_log.push_back(c);
        end
    endtask

    task automatic go();
        step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] ms, input logic w, input logic [63:0] x, input logic [63:0] y);
        int n;
        n = 0;
        while (cyc <= busy_hi && n < 200) begin go(); n++; end
        mul_signed = ms; mulw = w; multiplicand = x; multiplier = y;
        mul_valid = 1'b1;
        go();
        mul_valid = 1'b0;
        multiplicand = {$urandom, $urandom};
        multiplier   = {$urandom, $urandom};
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (q.size() > 0 && n < 200) begin go(); n++; end
        chk("drain", 128'(q.size()), 128'(0));
        q.delete();
    endtask

    task automatic run_lit(input string name, input logic [1:0] ms, input logic w,
                           input logic [63:0] x, input logic [63:0] y,
                           input logic [63:0] ehi, input logic [63:0] elo, input int elat);
        chk({name, "_model"}, prod(ms, w, x, y), {ehi, elo});
        issue(ms, w, x, y);
        wait_done();
        chk({name, "_hi"}, 128'(last_hi), 128'(ehi));
        chk({name, "_lo"}, 128'(last_lo), 128'(elo));
        if (elat >= 0) chk({name, "_lat"}, 128'(last_due - last_acc_c), 128'(elat));
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0: return 64'h0;
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'h7FFF_FFFF_FFFF_FFFF;
            4: return 64'($urandom_range(0, 255));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0] ms;
        rst = 1'b1; mul_valid = 1'b0; flush = 1'b0; mulw = 1'b0;
        mul_signed = 2'b00; multiplicand = '0; multiplier = '0;
        repeat (3) go();
        rst = 1'b0;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_ready",     128'(mul_ready), 128'(1));
        chk("rst_hi",        128'(result_hi), 128'(0));
        chk("rst_lo",        128'(result_lo), 128'(0));
        chk("rst_pg",        128'({pg_x, pg_src}), 128'(0));
        chk_en = 1'b1;

        run_lit("ss_m3x5", 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5,
                64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF1, EARLY ? -1 : 34);
        run_lit("uu_max", 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001, -1);
        run_lit("su_m1", 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, -1);
        run_lit("mulw_ss", 2'b11, 1'b1, 64'hDEAD_0000_4000_0000, 64'd2,
                64'h0, 64'hFFFF_FFFF_8000_0000, EARLY ? -1 : 18);
        run_lit("ss_3x1", 2'b11, 1'b0, 64'd3, 64'd1, 64'h0, 64'd3, EARLY ? 3 : 34);

        // Flush in BUSY cycle 10, then a fresh op.
        issue(2'b11, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h4000_0000_0000_0000);
        repeat (10) go();
        flush = 1'b1;
        go();
        flush = 1'b0;
        chk("ready_after_flush", 128'(mul_ready), 128'(1));
        run_lit("ss_7x6", 2'b11, 1'b0, 64'd7, 64'd6, 64'h0, 64'd42, -1);

        // flush together with a request in IDLE drops the request.
        mul_valid = 1'b1; flush = 1'b1;
        go();
        mul_valid = 1'b0; flush = 1'b0;
        repeat (3) go();

        // mul_valid held high: one accept per N+2 cycles.
        acc_log.delete();
        mul_signed = 2'b00; mulw = 1'b0;
        multiplicand = 64'h0123_4567_89AB_CDEF; multiplier = 64'h8000_0000_0000_0001;
        mul_valid = 1'b1;
        repeat (80) go();
        mul_valid = 1'b0;
        wait_done();
        chk("hold_accepts", 128'(acc_log.size()), 128'(3));
        if (acc_log.size() >= 2) chk("hold_spacing", 128'(acc_log[1] - acc_log[0]), 128'(NWIN64 + 2));

        // Reset in the middle of an op clears the result registers.
        issue(2'b10, 1'b0, 64'hFFFF_0000_1111_2222, 64'h0F0F_0F0F_0F0F_0F0F);
        repeat (5) go();
        rst = 1'b1;
        go();
        rst = 1'b0;
        chk("midrst_hi",    128'(result_hi), 128'(0));
        chk("midrst_lo",    128'(result_lo), 128'(0));
        chk("midrst_ready", 128'(mul_ready), 128'(1));

        // Randomized operations with stray requests and occasional flush.
        for (int k = 0; k < 60; k++) begin
            ms = 2'($urandom_range(0, 3));
            issue(ms, 1'($urandom_range(0, 1)), pick(), pick());
            repeat ($urandom_range(0, 40)) begin
                mul_valid = 1'($urandom_range(0, 1));
                go();
            end
            mul_valid = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                flush = 1'b1;
                go();
                flush = 1'b0;
            end
            wait_done();
        end

        repeat (3) go();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
